bus_ram_responder: RTL and testbench
====================================

Name: bus_ram_responder

Overview:
- Bus-side responder for the load/store traffic the CPU control path issues: decodes the size/sign field, applies byte-lane masks, and performs word-array reads and writes.
- Sits between the CPU bus master and a local data RAM, with a programmable number of wait states.
- Converts SB/SH/SW stores into byte-enabled writes, and LB/LH/LW/LBU/LHU loads into extended read data.

Parameters:
- DEPTH, 64: number of 32-bit words in the RAM.
- BASE_ADDR, 32'h1000_0000: byte address of word 0.
- WAIT_CYCLES, 0: extra cycles between request capture and response (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- busReq  input  1  master request valid; held by master until busReady.
- busWe  input  1  1 = store, 0 = load.
- busAddr  input  32  byte address.
- busFunct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- busWData  input  32  store data, right-aligned (bits [7:0] for B, [15:0] for H).
- busRData  output  32  load data, extended per busFunct3; valid only while busReady=1.
- busReady  output  1  one-cycle completion strobe.
- busErr  output  1  error flag, qualified by busReady.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busReady=0, busRData=0, busErr=0, wait counter=0. RAM contents are not cleared.
- Reset mid-transaction: the transaction is abandoned, no RAM write occurs, and the responder returns to IDLE.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: when busReq=1, register busWe, busAddr, busFunct3 and busWData. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0, go to RESP.
  - RESP: busReady=1 for exactly one cycle, then go to IDLE.
- busReq, busWe, busAddr, busFunct3 and busWData are ignored in WAIT and RESP.
- Latency: request sampled at edge N; busReady is high during cycle N+1+WAIT_CYCLES.
- Back-to-back: if busReq is still 1 in the cycle after RESP, IDLE captures a new transaction. Minimum spacing between busReady pulses is 2+WAIT_CYCLES cycles.
- Address decode:
  - off = addr - BASE_ADDR (32-bit unsigned).
  - In range iff off < DEPTH*4.
  - Word index = off[$clog2(DEPTH)+1:2]; lane = off[1:0].
- Out-of-range access: write dropped, busRData=0, busErr=1. This applies with or without the macro.
- Store: a byte-enabled write is committed on the clock edge that ends RESP.
  - SB: byte enable 1<<lane; busWData[7:0] replicated to all lanes.
  - SH: enable 4'b0011<<lane; busWData[15:0] replicated.
  - SW: enable 4'b1111.
  - Unselected bytes keep their old value.
- Load: the word is read combinationally from the captured index, and busRData is registered into RESP.
  - Byte or halfword selected by lane.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- busRData holds its last value outside RESP and is forced to 0 only by reset.
- Funct3 values 011, 110 and 111 (unsupported): handling is given under Optional Feature.

Optional Feature:
- Macro: BUS_MISALIGN_ERR_EN.
- Defined:
  - Misaligned accesses (H with lane[0]=1, W with lane!=0) and unsupported funct3 produce busErr=1 in RESP.
  - No write occurs and busRData=0.
- Undefined:
  - busErr is asserted only for out-of-range accesses.
  - Misaligned H uses lane {lane[1],1'b0}, and misaligned W uses lane 0 (low bits ignored).
  - Unsupported funct3 is treated as W.

Test Plan:
1. Reset with WAIT_CYCLES=0: SW addr 0x1000_0004, data 0xDEADBEEF, then LW same address -> busReady one cycle after each capture, busRData=0xDEADBEEF, busErr=0.
2. SB 0x1000_0005 data 0x80, then LB and LBU at the same address -> 0xFFFF_FF80 and 0x0000_0080. LW 0x1000_0004 -> 0xDEAD80EF.
3. WAIT_CYCLES=3: hold busReq for LW -> busReady exactly in cycle N+4. busReq held high afterwards -> next busReady at cycle N+9.
4. LH at 0x1000_0003 -> with BUS_MISALIGN_ERR_EN: busErr=1, busRData=0. Without the macro: halfword from lane 2, busErr=0.
5. SW to BASE_ADDR+DEPTH*4 -> busErr=1 and RAM unchanged; LW to BASE_ADDR-4 -> busRData=0, busErr=1.
6. Assert reset during WAIT of an SW -> busReady stays 0. A subsequent LW to the same address returns the pre-store value.

Source files
------------

// File: rtl/bus_ram_responder.sv
// Load/store bus responder in front of a byte-lane data RAM with programmable wait states.
// Optional BUS_MISALIGN_ERR_EN: flag misaligned and unsupported accesses as errors instead of aligning them.
module bus_ram_responder #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [2:0]  busFunct3,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] src_addr;
  logic [2:0]  src_funct3;
  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [1:0]  lane_raw;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        unsupported;
  logic        misaligned;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic        wr_en;

  // With zero wait states the response is computed straight from the live request
  // on the capture edge; otherwise the captured copy drives the datapath.
  assign src_addr   = (state_reg == IDLE) ? busAddr   : addr_reg;
  assign src_funct3 = (state_reg == IDLE) ? busFunct3 : funct3_reg;

  assign off         = src_addr - BASE_ADDR;
  assign in_range    = (off < SPAN);
  assign idx         = off[AW+1:2];
  assign lane_raw    = off[1:0];
  assign size        = src_funct3[1:0];
  assign unsupported = (src_funct3 == 3'b011) || (src_funct3[2:1] == 2'b11);
  assign misaligned  = ((size == 2'b01) && lane_raw[0]) || (size[1] && (lane_raw != 2'b00));

`ifdef BUS_MISALIGN_ERR_EN
  assign acc_err = !in_range || unsupported || misaligned;
`else
  assign acc_err = !in_range;
`endif

  always_comb begin
    lane = 2'b00;
    case (size)
      2'b00:   lane = lane_raw;
      2'b01:   lane = {lane_raw[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) begin
          mem[idx] <= wr_data[8*gi +: 8];
        end
      end
      assign rd_word[8*gi +: 8] = mem[idx];
    end
  endgenerate

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
  end
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (src_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = rd_word;
    endcase
    if (acc_err) begin
      load_data = 32'd0;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be      = 4'b1111;
    wr_data = wdata_reg;
    case (size)
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << lane;
        wr_data = {2{wdata_reg[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = wdata_reg;
      end
    endcase
  end

  assign wr_en = (state_reg == RESP) && we_reg && !acc_err;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (busReq) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 32'd0;
      funct3_reg <= 3'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if ((state_reg == IDLE) && busReq) begin
        we_reg     <= busWe;
        addr_reg   <= busAddr;
        funct3_reg <= busFunct3;
        wdata_reg  <= busWData;
      end
      if (state_next == RESP) begin
        rdata_reg <= load_data;
        err_reg   <= acc_err;
      end
    end
  end

  assign busReady = (state_reg == RESP);
  assign busRData = rdata_reg;
  assign busErr   = err_reg;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: one zero-wait and one three-wait instance against a byte-addressed model.
module tb_bus_ram_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [2:0]  f3    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];

  logic [7:0] mdl [2][DEPTH*4];

  int checks = 0;
  int errors = 0;

  bus_ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .busReq(req[0]), .busWe(we[0]), .busAddr(addr[0]),
    .busFunct3(f3[0]), .busWData(wdata[0]), .busRData(rdata[0]), .busReady(rdy[0]), .busErr(err[0])
  );

  bus_ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .busReq(req[1]), .busWe(we[1]), .busAddr(addr[1]),
    .busFunct3(f3[1]), .busWData(wdata[1]), .busRData(rdata[1]), .busReady(rdy[1]), .busErr(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: memory is a flat byte array; an access touches `size` consecutive bytes.
  task automatic model(input int i, input logic wr, input logic [31:0] a, input logic [2:0] fn,
                       input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
    logic [31:0] off;
    int unsigned size;
    logic        uns;
    logic [31:0] v;
    off  = a - BASE;
    size = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
    uns  = (fn == 3'b011) || (fn == 3'b110) || (fn == 3'b111);
    eerr = (off >= SPAN);
`ifdef BUS_MISALIGN_ERR_EN
    if (uns || (off % size) != 0) eerr = 1'b1;
`else
    if (uns) eerr = eerr;
`endif
    off = off - (off % size);
    erd = 32'd0;
    if (!eerr) begin
      if (wr) begin
        for (int b = 0; b < int'(size); b++) mdl[i][off + b] = wd[8*b +: 8];
      end else begin
        v = 32'd0;
        for (int b = 0; b < int'(size); b++) v = v | (32'(mdl[i][off + b]) << (8 * b));
        if (!fn[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!fn[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        erd = v;
      end
    end
  endtask

  task automatic run(input int i, input logic w, input logic [31:0] a, input logic [2:0] fn,
                     input logic [31:0] wd, input string tag,
                     output logic [31:0] rd_o, output logic err_o);
    logic [31:0] erd, grd;
    logic        eerr, gerr;
    int          lat;
    bit          got;
    model(i, w, a, fn, wd, erd, eerr);
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; f3[i] = fn; wdata[i] = wd;
    got = 1'b0; lat = 0; grd = 32'd0; gerr = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rdy[i]) begin
        got = 1'b1; lat = k; grd = rdata[i]; gerr = err[i];
        break;
      end
    end
    req[i] = 1'b0;
    chk({tag, "_ready"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), (i == 0) ? 32'd1 : 32'd4);
    chk({tag, "_err"}, 32'(gerr), 32'(eerr));
    if (!w) chk({tag, "_rdata"}, grd, erd);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(rdy[i]), 32'd0);
    rd_o  = grd;
    err_o = gerr;
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic        er, eerr;
    int          first, second;
    bit          seen;
    int          i;
    logic        w;
    logic [2:0]  fn;
    logic [31:0] a;
    int          r;

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; f3[k] = 3'd0; wdata[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(rdy[k]), 32'd0);
      chk("reset_err", 32'(err[k]), 32'd0);
      chk("reset_rdata", rdata[k], 32'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int wi = 0; wi < DEPTH; wi++)
        run(k, 1'b1, BASE + 32'(4 * wi), 3'b010, $urandom, "init", rd, er);

    run(0, 1'b1, BASE + 32'h4, 3'b010, 32'hDEAD_BEEF, "p1_sw", rd, er);
    run(0, 1'b0, BASE + 32'h4, 3'b010, 32'd0, "p1_lw", rd, er);
    chk("p1_value", rd, 32'hDEAD_BEEF);

    run(0, 1'b1, BASE + 32'h5, 3'b000, 32'h0000_0080, "p2_sb", rd, er);
    run(0, 1'b0, BASE + 32'h5, 3'b000, 32'd0, "p2_lb", rd, er);
    chk("p2_lb_value", rd, 32'hFFFF_FF80);
    run(0, 1'b0, BASE + 32'h5, 3'b100, 32'd0, "p2_lbu", rd, er);
    chk("p2_lbu_value", rd, 32'h0000_0080);
    run(0, 1'b0, BASE + 32'h4, 3'b010, 32'd0, "p2_lw", rd, er);
    chk("p2_lw_value", rd, 32'hDEAD_80EF);

    run(1, 1'b0, BASE + 32'h4, 3'b010, 32'd0, "p3_lw", rd, er);
    model(1, 1'b0, BASE + 32'h4, 3'b010, 32'd0, erd, eerr);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE + 32'h4; f3[1] = 3'b010;
    first = 0; second = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (rdy[1]) begin
        if (first == 0) first = k;
        else begin
          second = k;
          break;
        end
      end
    end
    req[1] = 1'b0;
    chk("p3_first_ready", 32'(first), 32'd4);
    chk("p3_second_ready", 32'(second), 32'd9);
    chk("p3_b2b_rdata", rdata[1], erd);
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      run(k, 1'b0, BASE + 32'h3, 3'b001, 32'd0, "p4_lh", rd, er);
`ifdef BUS_MISALIGN_ERR_EN
      chk("p4_lh_err", 32'(er), 32'd1);
      chk("p4_lh_rdata", rd, 32'd0);
`else
      chk("p4_lh_err", 32'(er), 32'd0);
`endif
    end

    run(0, 1'b1, BASE + SPAN, 3'b010, 32'h1234_5678, "p5_sw_oor", rd, er);
    chk("p5_sw_oor_err", 32'(er), 32'd1);
    run(0, 1'b0, BASE, 3'b010, 32'd0, "p5_lw_word0", rd, er);
    run(0, 1'b0, BASE + SPAN - 32'd4, 3'b010, 32'd0, "p5_lw_last", rd, er);
    run(0, 1'b0, BASE - 32'd4, 3'b010, 32'd0, "p5_lw_below", rd, er);
    chk("p5_below_rdata", rd, 32'd0);
    chk("p5_below_err", 32'(er), 32'd1);

    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = BASE + 32'h8; f3[1] = 3'b010; wdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rdy[1]) seen = 1'b1;
    end
    chk("p6_no_ready", 32'(seen), 32'd0);
    chk("p6_rdata_reset", rdata[1], 32'd0);
    chk("p6_err_reset", 32'(err[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    run(1, 1'b0, BASE + 32'h8, 3'b010, 32'd0, "p6_lw", rd, er);

    for (int n = 0; n < 300; n++) begin
      i  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      fn = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 19));
      if (r == 0)      a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else if (r == 1) a = BASE + SPAN + 32'($urandom_range(0, 7));
      else             a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      run(i, w, a, fn, $urandom, "rand", rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
